program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction-cache download interface; the CPU's `write` / `write_instruction_index` / `write_instruction` inputs are its consumer.
- Takes a framed byte stream from a host link (UART receiver or similar) through a valid/ready handshake.
- Assembles the bytes into 16-bit instructions, issues them to consecutive cache slots and holds `write` high for the whole load, which freezes the CPU pipeline.
- Checks a trailing XOR checksum and reports done or error.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum cycles between accepted bytes inside a frame. Must be ≥2.
- TO_W, $clog2(TIMEOUT_CYCLES), timeout counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader can accept a byte this cycle.
- clear  in  1  abort or acknowledge; returns to IDLE.
- write  out  1  cache write enable / CPU hold; wire to CPU `write`.
- write_instruction_index  out  8  cache slot.
- write_instruction  out  16  instruction in memory byte order ({first byte, second byte}); downstream endian inversion is unchanged.
- load_done  out  1  frame loaded, checksum good.
- load_error  out  1  checksum mismatch or timeout.

Behaviour:
- One clock; reset is synchronous and active-low.
- Frame format: SYNC_BYTE, LEN, 2×N payload bytes, CSUM.
  - N = LEN, except LEN=0 means 256.
  - CSUM = XOR of all payload bytes.
- A byte is accepted on a rising edge where rx_valid && rx_ready.
- rx_ready is combinational: 1 in IDLE/LEN/HI/LO/CSUM, 0 in DONE/ERROR, and 0 whenever reset_n=0.
- Reset (reset_n=0 at an edge): state=IDLE; write, load_done, load_error, write_instruction_index, write_instruction, internal counters and csum all 0. Applies mid-load too: write drops at that edge and the cache keeps partial contents.
- IDLE:
  - Accepted byte == SYNC_BYTE → LEN.
  - Any other byte is dropped; stay in IDLE.
- LEN (on accept):
  - remaining←(byte==0 ? 256 : byte) (9-bit), slot←0, csum←0, write←1.
  - → HI.
- HI (on accept): hi←byte, csum←csum^byte; → LO.
- LO (on accept):
  - write_instruction←{hi,byte}, write_instruction_index←slot, csum←csum^byte.
  - slot←slot+1 (8-bit, wraps 255→0), remaining←remaining−1.
  - → CSUM if remaining was 1, else → HI.
- Cache write timing:
  - The cache captures the pair at the edge following the LO accept.
  - Outputs then hold until the next LO accept.
  - While write=1 the cache rewrites the held pair every cycle; this is idempotent.
  - Between LEN and the first LO accept it writes 0x0000 to slot 0, which the first instruction then overwrites.
- CSUM (on accept):
  - byte==csum → DONE: load_done←1, write←0.
  - Otherwise → ERROR: load_error←1, write←0.
- Timeout (states LEN/HI/LO/CSUM):
  - Counter clears on entry to LEN and on every accepted byte; otherwise it increments.
  - If the counter == TIMEOUT_CYCLES−1 and no byte is accepted this cycle → ERROR (load_error←1, write←0).
  - An accept in the same cycle wins over the timeout.
- DONE/ERROR: outputs hold; no bytes accepted.
- clear=1 in any state → IDLE at that edge, with write, load_done and load_error ←0.
  - Index and instruction outputs hold their values.
  - Priority: reset_n > clear > byte accept > timeout.
- load_done and load_error are never both 1.
- write is 1 exactly from the edge after the LEN accept until the edge leaving LEN/HI/LO/CSUM.

Test Plan:
- Good frame, 2 instructions: bytes A5, 02, 20, 05, 46, C0, A3 → cache slot0=0x2005, slot1=0x46C0; load_done=1; write=0 after the CSUM edge; CPU resumes.
- Bad checksum: same frame with CSUM=00 → load_error=1, load_done=0, write=0. Then clear → IDLE and flags=0.
- Noise before sync: bytes 00, FF, 5A, then the good frame → leading bytes ignored, same result as the good-frame case; rx_valid gaps of 3 cycles between bytes are tolerated.
- Timeout, TIMEOUT_CYCLES=16: A5, 03, 11, then stall → load_error=1 exactly 16 cycles after the 11 accept; write=0. A byte arriving on cycle 15 keeps the load alive.
- LEN=00: 512 payload bytes with value k&FF, correct CSUM → slots 0..255 written, final index 0xFF, load_done=1.
- Reset mid-load: reset_n=0 during LO of a good frame → next edge: write=0, all outputs 0, state IDLE. Same test repeated with clear=1 instead of reset → IDLE, index and instruction outputs held.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-cache write bundle of the program loader.
// The loader takes the slave side; the host link and cache side take the master side.
interface program_loader_if;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        clear;
   logic        write;
   logic [7:0]  write_instruction_index;
   logic [15:0] write_instruction;
   logic        load_done;
   logic        load_error;

   modport master (
      output rx_valid, rx_data, clear,
      input  rx_ready, write, write_instruction_index, write_instruction, load_done, load_error
   );

   modport slave (
      input  rx_valid, rx_data, clear,
      output rx_ready, write, write_instruction_index, write_instruction, load_done, load_error
   );
endinterface

// File: rtl/program_loader.sv
// Receives a framed byte stream (SYNC, LEN, 2*N payload, CSUM) and writes 16-bit
// instructions into consecutive cache slots, holding write high for the whole load.
module program_loader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter int         TO_W           = $clog2(TIMEOUT_CYCLES)
) (
   input  logic             clk,
   input  logic             reset_n,
   program_loader_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, LEN, HI, LO, CSUM, DONE, ERROR} state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_t          state_reg, state_next;
   logic [8:0]      remaining_reg, remaining_next;
   logic [7:0]      slot_reg, slot_next;
   logic [7:0]      hi_reg, hi_next;
   logic [7:0]      csum_reg, csum_next;
   logic [7:0]      index_reg, index_next;
   logic [15:0]     instr_reg, instr_next;
   logic [TO_W-1:0] timer_reg, timer_next;
   logic            write_reg, write_next;
   logic            done_reg, done_next;
   logic            error_reg, error_next;
   logic            ready;
   logic            accept;
   logic            in_frame;

   assign ready    = reset_n && (state_reg != DONE) && (state_reg != ERROR);
   assign accept   = bus.rx_valid && ready;
   assign in_frame = (state_reg == LEN) || (state_reg == HI) ||
                     (state_reg == LO)  || (state_reg == CSUM);

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      slot_next      = slot_reg;
      hi_next        = hi_reg;
      csum_next      = csum_reg;
      index_next     = index_reg;
      instr_next     = instr_reg;
      timer_next     = timer_reg;
      write_next     = write_reg;
      done_next      = done_reg;
      error_next     = error_reg;

      if (bus.clear) begin
         state_next = IDLE;
         write_next = 1'b0;
         done_next  = 1'b0;
         error_next = 1'b0;
         timer_next = '0;
      end else if (accept) begin
         timer_next = '0;
         case (state_reg)
            IDLE: begin
               if (bus.rx_data == SYNC_BYTE) state_next = LEN;
            end
            LEN: begin
               // Zeroed pair makes the pre-first-instruction rewrite land as 0x0000 in slot 0.
               remaining_next = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
               slot_next      = 8'd0;
               csum_next      = 8'd0;
               index_next     = 8'd0;
               instr_next     = 16'd0;
               write_next     = 1'b1;
               state_next     = HI;
            end
            HI: begin
               hi_next    = bus.rx_data;
               csum_next  = csum_reg ^ bus.rx_data;
               state_next = LO;
            end
            LO: begin
               instr_next     = {hi_reg, bus.rx_data};
               index_next     = slot_reg;
               csum_next      = csum_reg ^ bus.rx_data;
               slot_next      = slot_reg + 8'd1;
               remaining_next = remaining_reg - 9'd1;
               state_next     = (remaining_reg == 9'd1) ? CSUM : HI;
            end
            CSUM: begin
               write_next = 1'b0;
               if (bus.rx_data == csum_reg) begin
                  done_next  = 1'b1;
                  state_next = DONE;
               end else begin
                  error_next = 1'b1;
                  state_next = ERROR;
               end
            end
            default: ;
         endcase
      end else if (in_frame) begin
         if (timer_reg == TO_LAST) begin
            error_next = 1'b1;
            write_next = 1'b0;
            state_next = ERROR;
         end else begin
            timer_next = timer_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         slot_reg      <= '0;
         hi_reg        <= '0;
         csum_reg      <= '0;
         index_reg     <= '0;
         instr_reg     <= '0;
         timer_reg     <= '0;
         write_reg     <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         slot_reg      <= slot_next;
         hi_reg        <= hi_next;
         csum_reg      <= csum_next;
         index_reg     <= index_next;
         instr_reg     <= instr_next;
         timer_reg     <= timer_next;
         write_reg     <= write_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
      end
   end

   assign bus.rx_ready                = ready;
   assign bus.write                   = write_reg;
   assign bus.write_instruction_index = index_reg;
   assign bus.write_instruction       = instr_reg;
   assign bus.load_done               = done_reg;
   assign bus.load_error              = error_reg;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected cache pairs are queued as LO bytes are
// driven and popped when the cache-side outputs change while write is high.
module tb_program_loader;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   program_loader_if bus ();

   program_loader #(
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic [7:0]  idx;
      logic [15:0] instr;
   } pair_t;

   int          pass_cnt  = 0;
   int          total_cnt = 0;
   pair_t       exp_q[$];
   logic [7:0]  payload[$];
   logic [15:0] cache[256];
   logic [7:0]  prev_idx;
   logic [15:0] prev_instr;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total_cnt++;
      assert (obs === expv) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Cache model and scoreboard: a new pair on the outputs while write is high is one issued instruction.
   always @(negedge clk) begin
      if (reset_n === 1'b1 && bus.write === 1'b1) begin
         cache[bus.write_instruction_index] = bus.write_instruction;
         if ((bus.write_instruction_index != prev_idx || bus.write_instruction != prev_instr) &&
             !(bus.write_instruction_index == 8'd0 && bus.write_instruction == 16'd0)) begin
            if (exp_q.size() == 0) begin
               check("pair_unexpected", {8'h00, bus.write_instruction_index, bus.write_instruction}, 32'hFFFF_FFFF);
            end else begin
               pair_t e;
               e = exp_q.pop_front();
               check("pair", {8'h00, bus.write_instruction_index, bus.write_instruction}, {8'h00, e});
            end
         end
      end
      prev_idx   = bus.write_instruction_index;
      prev_instr = bus.write_instruction;
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(negedge clk);
      while (bus.rx_ready !== 1'b1 && n < 32) begin
         n++;
         @(negedge clk);
      end
      if (n >= 32) check("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_pair(input logic [7:0] idx, input logic [15:0] instr);
      pair_t p;
      p.idx   = idx;
      p.instr = instr;
      exp_q.push_back(p);
   endtask

   task automatic send_frame(input logic [7:0] len, input logic [7:0] csum_flip, input int gap);
      logic [7:0] cs = 8'h00;
      send_byte(8'hA5, gap);
      send_byte(len, 0);
      check("write_after_len", 32'(bus.write), 32'd1);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      for (int k = 0; k < payload.size(); k++) begin
         cs = cs ^ payload[k];
         if (k[0]) push_pair(8'(k / 2), {payload[k-1], payload[k]});
         send_byte(payload[k], gap);
      end
      send_byte(cs ^ csum_flip, gap);
   endtask

   task automatic check_end(input string tag, input logic done_exp, input logic err_exp);
      check({tag, "_done"}, 32'(bus.load_done), 32'(done_exp));
      check({tag, "_error"}, 32'(bus.load_error), 32'(err_exp));
      check({tag, "_write"}, 32'(bus.write), 32'd0);
      check({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic pulse_clear();
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
   endtask

   task automatic fill_cache();
      for (int i = 0; i < 256; i++) cache[i] = 16'hDEAD;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int bad;
      logic [7:0] cs;

      reset_n      = 1'b0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.clear    = 1'b0;
      fill_cache();

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_write", 32'(bus.write), 32'd0);
      check("rst_index", 32'(bus.write_instruction_index), 32'd0);
      check("rst_instr", 32'(bus.write_instruction), 32'd0);
      check("rst_done", 32'(bus.load_done), 32'd0);
      check("rst_error", 32'(bus.load_error), 32'd0);
      check("rst_ready", 32'(bus.rx_ready), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      #1;
      check("ready_idle", 32'(bus.rx_ready), 32'd1);

      // Good frame, two instructions
      payload = '{8'h20, 8'h05, 8'h46, 8'hC0};
      send_frame(8'h02, 8'h00, 0);
      check_end("good", 1'b1, 1'b0);
      check("good_slot0", 32'(cache[0]), 32'h2005);
      check("good_slot1", 32'(cache[1]), 32'h46C0);
      pulse_clear();
      check("clr_done", 32'(bus.load_done), 32'd0);
      check("clr_ready", 32'(bus.rx_ready), 32'd1);
      check("clr_index_held", 32'(bus.write_instruction_index), 32'd1);
      check("clr_instr_held", 32'(bus.write_instruction), 32'h46C0);

      // Bad checksum: CSUM forced to 00
      send_frame(8'h02, 8'hA3, 0);
      check_end("badcs", 1'b0, 1'b1);
      pulse_clear();
      check("badcs_clr_error", 32'(bus.load_error), 32'd0);
      check("badcs_clr_done", 32'(bus.load_done), 32'd0);

      // Noise before sync, 3-cycle gaps
      fill_cache();
      send_byte(8'h00, 3);
      send_byte(8'hFF, 3);
      send_byte(8'h5A, 3);
      check("noise_write", 32'(bus.write), 32'd0);
      send_frame(8'h02, 8'h00, 3);
      check_end("noise", 1'b1, 1'b0);
      check("noise_slot0", 32'(cache[0]), 32'h2005);
      check("noise_slot1", 32'(cache[1]), 32'h46C0);
      pulse_clear();

      // Timeout after stall
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      k = 0;
      while (k < 40) begin
         k++;
         @(posedge clk);
         #1;
         if (bus.load_error === 1'b1) break;
      end
      check("timeout_cycles", 32'(k), 32'd16);
      check("timeout_write", 32'(bus.write), 32'd0);
      check("timeout_done", 32'(bus.load_done), 32'd0);
      pulse_clear();

      // A byte landing on the last allowed cycle keeps the load alive
      send_byte(8'hA5, 0);
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      repeat (15) @(posedge clk);
      #1;
      check("alive_no_error", 32'(bus.load_error), 32'd0);
      push_pair(8'd0, 16'h1122);
      send_byte(8'h22, 0);
      check("alive_write", 32'(bus.write), 32'd1);
      send_byte(8'h33, 0);
      push_pair(8'd1, 16'h3344);
      send_byte(8'h44, 0);
      send_byte(8'h55, 0);
      push_pair(8'd2, 16'h5566);
      send_byte(8'h66, 0);
      cs = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44 ^ 8'h55 ^ 8'h66;
      send_byte(cs, 0);
      check_end("alive", 1'b1, 1'b0);
      pulse_clear();

      // LEN=0 means 256 instructions
      fill_cache();
      payload.delete();
      for (int i = 0; i < 512; i++) payload.push_back(8'(i));
      send_frame(8'h00, 8'h00, 0);
      check_end("len0", 1'b1, 1'b0);
      bad = 0;
      for (int i = 0; i < 256; i++)
         if (cache[i] !== {8'(2 * i), 8'(2 * i + 1)}) bad++;
      check("len0_bad_slots", 32'(bad), 32'd0);
      check("len0_index", 32'(bus.write_instruction_index), 32'hFF);
      check("len0_instr", 32'(bus.write_instruction), 32'hFEFF);
      pulse_clear();

      // Reset in the middle of a load (sitting in LO)
      fill_cache();
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h20, 0);
      push_pair(8'd0, 16'h2005);
      send_byte(8'h05, 0);
      send_byte(8'h46, 0);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_write", 32'(bus.write), 32'd0);
      check("midrst_index", 32'(bus.write_instruction_index), 32'd0);
      check("midrst_instr", 32'(bus.write_instruction), 32'd0);
      check("midrst_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
      check("midrst_cache_kept", 32'(cache[0]), 32'h2005);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Clear in the middle of a load
      send_byte(8'hA5, 0);
      send_byte(8'h02, 0);
      send_byte(8'h20, 0);
      push_pair(8'd0, 16'h2005);
      send_byte(8'h05, 0);
      send_byte(8'h46, 0);
      pulse_clear();
      check("midclr_write", 32'(bus.write), 32'd0);
      check("midclr_index_held", 32'(bus.write_instruction_index), 32'd0);
      check("midclr_instr_held", 32'(bus.write_instruction), 32'h2005);
      check("midclr_flags", {30'd0, bus.load_done, bus.load_error}, 32'd0);
      check("midclr_ready", 32'(bus.rx_ready), 32'd1);
      check("midclr_queue", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
